pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS-32 core. Sits beside the decode stage and drives the PC, IF/ID and ID/EX
//  enables. Handles three events:
//   - load-use stalls, from decoded ID fields and the EX-stage load destination
//   - taken-branch/jump flushes, signalled from EX
//   - HALT drain-and-stop
// PARAMETERS
//  STALL_CYC   1   bubbles inserted per load-use hazard (1..7)
//  DRAIN_CYC   3   cycles after HALT in ID before halted asserts (stages EX, MEM, WB retire)
//  CNT_W       16  width of stall statistics counter
// PORTS
//  clk            in   1   rising-edge clock, single domain
//  rst_n          in   1   synchronous, active-low reset
//  id_valid       in   1   IF/ID register holds a real instruction
//  id_type        in   2   decoded class: R=0, J=1, HALT=2, I=3
//  id_opcode      in   6   instruction[31:26] of ID instruction
//  id_rs          in   5   source register of ID instruction
//  id_rt          in   5   target register of ID instruction
//  ex_valid       in   1   ID/EX register holds a real instruction
//  ex_mem_read    in   1   EX instruction is LW (opcode 100011)
//  ex_rt          in   5   EX load destination register
//  ex_redirect    in   1   EX resolved taken branch or jump; PC being redirected this cycle
//  resume         in   1   leave HALTED state (debug restart)
//  pc_en          out  1   PC register load enable
//  ifid_en        out  1   IF/ID register load enable
//  ifid_flush     out  1   clear IF/ID valid at next edge
//  idex_bubble    out  1   load NOP (valid=0) into ID/EX at next edge
//  halted         out  1   core stopped
//  stall_count    out  CNT_W  saturating count of load-use bubble cycles
// BEHAVIOUR
//  - FSM states: RUN, STALL, DRAIN, HALTED. State register and counters update on posedge clk only.
//  - Outputs are combinational from state plus inputs, so the control decision applies at the same edge.
//  - Reset (rst_n=0 sampled at edge): state=RUN, counters=0.
//    While rst_n=0, outputs are forced: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, halted=0.
//  - rt_used = (id_type==R) | id_opcode in {101011 SW, 000100 BEQ, 000101 BNE}.
//  - hazard = id_valid & ex_valid & ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (rt_used & ex_rt==id_rt)).
//    For J type, rs is not compared.
//  - RUN, normal: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
//  - RUN, ex_redirect=1: ifid_flush=1, idex_bubble=1, pc_en=1.
//    Highest priority; masks hazard and HALT, because the ID instruction is on the wrong path.
//  - RUN, hazard: pc_en=0, ifid_en=0, idex_bubble=1.
//    If STALL_CYC>1, go to STALL with cnt=STALL_CYC-1; else stay in RUN.
//  - STALL: pc_en=0, ifid_en=0, idex_bubble=1. cnt decrements each cycle; at cnt==1, go to RUN.
//    ex_redirect cannot occur in STALL (EX holds a bubble). If it does asserts anyway, treat as RUN-redirect and go to RUN.
//  - RUN, id_valid & id_type==HALT & no redirect: pc_en=0, ifid_en=0, idex_bubble=1.
//    Go to DRAIN with cnt=DRAIN_CYC.
//  - DRAIN: same outputs as that HALT cycle. Decrement cnt; at cnt==1, go to HALTED.
//  - HALTED: pc_en=0, ifid_en=0, idex_bubble=1, halted=1.
//    resume=1 goes to RUN with ifid_flush=1, so HALT is discarded and fetch continues at the held PC+4 path.
//  - Hazard and HALT are mutually exclusive: HALT reads no registers.
//  - Reset mid-STALL or mid-DRAIN aborts to RUN on that edge.
// CONFIGURATION
//  STALL_STATS_EN defined: stall_count increments by 1 on every cycle with idex_bubble=1 caused by hazard or STALL
//    (not by flush, DRAIN or HALTED). It saturates at all-ones and clears on reset.
//  STALL_STATS_EN undefined: stall_count tied to 0 and no counter flops are synthesised.
// STRUCTURE
//  Package pipe_ctrl_pkg holds:
//   - instr_type_t (R, J, HALT, I)
//   - opcode constants OP_RTYPE, OP_J, OP_HALT, OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_BEQ, OP_BNE
//   - ctrl_state_t
//  Sub-module load_use_detect (purely combinational): rt_used decode and register compares, producing hazard.
//  The top module holds the FSM, down-counter (3 bits) and optional stats counter.
// TESTING
//  - Reset: hold rst_n=0 for 2 cycles -> pc_en=0, idex_bubble=1, halted=0, stall_count=0.
//    Release -> pc_en=1 next cycle.
//  - Load-use: EX LW rt=5, ID R-type rs=5 -> exactly 1 cycle pc_en=0, idex_bubble=1, then RUN.
//    Same with rt=0 -> no stall.
//  - rt compare gating: EX LW rt=8, ID ADDI (001000) with rt=8, rs=3 -> no stall.
//    ID SW with rt=8 -> stall.
//  - Redirect priority: ex_redirect=1 while ID holds HALT and a hazard is present -> ifid_flush=1, pc_en=1,
//    state stays RUN, halted stays 0.
//  - HALT: ID HALT with DRAIN_CYC=3 -> halted=1 on the 4th edge after detection.
//    resume=1 -> RUN, ifid_flush=1 for that cycle.
//  - Stats (STALL_STATS_EN, CNT_W=4, STALL_CYC=2): 10 back-to-back hazards -> stall_count saturates at 15.
//    Flush cycles are not counted.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and opcode constants for the pipeline
//                sequencer of the 5-stage MIPS-32 core.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Decoded instruction class supplied by the decode stage
    typedef enum logic [1:0] {
        IT_R    = 2'd0,
        IT_J    = 2'd1,
        IT_HALT = 2'd2,
        IT_I    = 2'd3
    } instr_type_t;

    // Primary opcodes, instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } ctrl_state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Combinational load-use hazard detector. Compares the
//                registers read by the ID instruction with the destination
//                of a load sitting in EX.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       i_id_valid,
    input  logic [1:0] i_id_type,
    input  logic [5:0] i_id_opcode,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_ex_valid,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rt,
    output logic       o_hazard
);

    logic w_rt_used;
    logic w_rs_used;
    logic w_rs_hit;
    logic w_rt_hit;

    // rt is only a source for R-type, stores and compare-branches; J reads no rs
    always_comb begin
        w_rt_used = (i_id_type == IT_R) || (i_id_opcode == OP_SW) ||
                    (i_id_opcode == OP_BEQ) || (i_id_opcode == OP_BNE);
        w_rs_used = (i_id_type != IT_J);
        w_rs_hit  = w_rs_used && (i_ex_rt == i_id_rs);
        w_rt_hit  = w_rt_used && (i_ex_rt == i_id_rt);
        o_hazard  = i_id_valid && i_ex_valid && i_ex_mem_read &&
                    (i_ex_rt != 5'd0) && (w_rs_hit || w_rt_hit);
    end

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Pipeline sequencer for the 5-stage MIPS-32 core. Drives the
//                PC, IF/ID and ID/EX enables for load-use stalls, taken
//                branch/jump flushes and HALT drain-and-stop.
//                Optional feature macro: STALL_STATS_EN (stall statistics
//                counter; stall_count is tied to zero when undefined).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_CYC = 1,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [1:0]       id_type,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_redirect,
    input  logic             resume,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [2:0] c_stall_init  = 3'(STALL_CYC - 1);
    localparam logic [2:0] c_drain_init  = 3'(DRAIN_CYC);
    localparam logic       c_multi_stall = (STALL_CYC > 1);

    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        w_hazard;
    logic        w_stall_bubble;

    load_use_detect u_load_use_detect (
        .i_id_valid    (id_valid),
        .i_id_type     (id_type),
        .i_id_opcode   (id_opcode),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_ex_valid    (ex_valid),
        .i_ex_mem_read (ex_mem_read),
        .i_ex_rt       (ex_rt),
        .o_hazard      (w_hazard)
    );

    // State and stall/drain down-counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and same-cycle pipeline control decisions
    always_comb begin
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        halted         = 1'b0;
        w_stall_bubble = 1'b0;
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;

        case (r_state)
            ST_RUN: begin
                if (ex_redirect) begin
                    // ID holds a wrong-path instruction: squash it, ignore hazard/HALT
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (w_hazard) begin
                    pc_en          = 1'b0;
                    ifid_en        = 1'b0;
                    idex_bubble    = 1'b1;
                    w_stall_bubble = 1'b1;
                    if (c_multi_stall) begin
                        w_state_nxt = ST_STALL;
                        w_cnt_nxt   = c_stall_init;
                    end
                end else if (id_valid && (id_type == IT_HALT)) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = c_drain_init;
                end
            end
            ST_STALL: begin
                if (ex_redirect) begin
                    // Not expected while EX holds a bubble; handled like a RUN redirect
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    pc_en          = 1'b0;
                    ifid_en        = 1'b0;
                    idex_bubble    = 1'b1;
                    w_stall_bubble = 1'b1;
                    w_cnt_nxt      = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                w_cnt_nxt   = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                halted      = 1'b1;
                if (resume) begin
                    // Discard the HALT still held in IF/ID and restart fetch
                    ifid_flush  = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 3'd0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 3'd0;
            end
        endcase

        // Reset holds the pipeline frozen and empty regardless of state
        if (!rst_n) begin
            pc_en          = 1'b0;
            ifid_en        = 1'b0;
            ifid_flush     = 1'b1;
            idex_bubble    = 1'b1;
            halted         = 1'b0;
            w_stall_bubble = 1'b0;
        end
    end

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] r_stall_count;

    // Saturating count of bubble cycles caused by load-use hazards
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall_bubble && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign stall_count = r_stall_count;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_stall_bubble;
    assign stall_count    = '0;
`endif

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Directed self-checking bench for pipeline_hazard_ctrl.
//                dut_a uses default parameters, dut_b uses STALL_CYC=2,
//                CNT_W=4; both see identical stimulus. Stats checks follow
//                the STALL_STATS_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [1:0] id_type;
    logic [5:0] id_opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_valid;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       ex_redirect;
    logic       resume;

    logic        a_pc_en, a_ifid_en, a_ifid_flush, a_idex_bubble, a_halted;
    logic [15:0] a_stall_count;
    logic        b_pc_en, b_ifid_en, b_ifid_flush, b_idex_bubble, b_halted;
    logic [3:0]  b_stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.STALL_CYC(1), .DRAIN_CYC(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_type(id_type),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .ex_valid(ex_valid),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
        .resume(resume), .pc_en(a_pc_en), .ifid_en(a_ifid_en),
        .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble),
        .halted(a_halted), .stall_count(a_stall_count)
    );

    pipeline_hazard_ctrl #(.STALL_CYC(2), .DRAIN_CYC(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_type(id_type),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .ex_valid(ex_valid),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
        .resume(resume), .pc_en(b_pc_en), .ifid_en(b_ifid_en),
        .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble),
        .halted(b_halted), .stall_count(b_stall_count)
    );

    // Quiet pipeline inputs; rst_n untouched
    task automatic set_idle();
        id_valid = 1'b0; id_type = IT_R; id_opcode = OP_RTYPE; id_rs = 5'd0; id_rt = 5'd0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0; ex_redirect = 1'b0; resume = 1'b0;
    endtask

    task automatic set_id(input logic [1:0] t, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        id_valid = 1'b1; id_type = t; id_opcode = op; id_rs = rs; id_rt = rt;
    endtask

    task automatic set_ex_lw(input logic [4:0] rt);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = rt;
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (a_pc_en !== 1'b0) begin n_fail++; $display("FAIL reset_pc_en: got %b expected 0", a_pc_en); end
        n_checks++; if (a_ifid_en !== 1'b0) begin n_fail++; $display("FAIL reset_ifid_en: got %b expected 0", a_ifid_en); end
        n_checks++; if (a_ifid_flush !== 1'b1) begin n_fail++; $display("FAIL reset_flush: got %b expected 1", a_ifid_flush); end
        n_checks++; if (a_idex_bubble !== 1'b1) begin n_fail++; $display("FAIL reset_bubble: got %b expected 1", a_idex_bubble); end
        n_checks++; if (a_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", a_halted); end
        n_checks++; if (a_stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_stall_count: got %0d expected 0", a_stall_count); end
        n_checks++; if (b_stall_count !== 4'd0) begin n_fail++; $display("FAIL reset_stall_count_b: got %0d expected 0", b_stall_count); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (a_pc_en !== 1'b1) begin n_fail++; $display("FAIL release_pc_en: got %b expected 1", a_pc_en); end
        n_checks++; if (a_idex_bubble !== 1'b0) begin n_fail++; $display("FAIL release_bubble: got %b expected 0", a_idex_bubble); end
        n_checks++; if (a_ifid_flush !== 1'b0) begin n_fail++; $display("FAIL release_flush: got %b expected 0", a_ifid_flush); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        set_ex_lw(5'd5);
        set_id(IT_R, OP_RTYPE, 5'd5, 5'd2);
        #1;
        n_checks++; if (a_pc_en !== 1'b0) begin n_fail++; $display("FAIL lu_pc_en: got %b expected 0", a_pc_en); end
        n_checks++; if (a_idex_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_bubble: got %b expected 1", a_idex_bubble); end
        n_checks++; if (a_ifid_en !== 1'b0) begin n_fail++; $display("FAIL lu_ifid_en: got %b expected 0", a_ifid_en); end
        n_checks++; if (b_pc_en !== 1'b0) begin n_fail++; $display("FAIL lu_b_pc_en: got %b expected 0", b_pc_en); end
        // EX now holds the inserted bubble
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        n_checks++; if (a_pc_en !== 1'b1) begin n_fail++; $display("FAIL lu_resume_pc_en: got %b expected 1", a_pc_en); end
        n_checks++; if (a_idex_bubble !== 1'b0) begin n_fail++; $display("FAIL lu_resume_bubble: got %b expected 0", a_idex_bubble); end
        n_checks++; if (b_pc_en !== 1'b0) begin n_fail++; $display("FAIL lu_b_stall2_pc_en: got %b expected 0", b_pc_en); end
        n_checks++; if (b_idex_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_b_stall2_bubble: got %b expected 1", b_idex_bubble); end
        @(negedge clk);
        #1;
        n_checks++; if (b_pc_en !== 1'b1) begin n_fail++; $display("FAIL lu_b_resume_pc_en: got %b expected 1", b_pc_en); end
        // Load into r0 never creates a hazard
        set_ex_lw(5'd0);
        set_id(IT_R, OP_RTYPE, 5'd0, 5'd0);
        #1;
        n_checks++; if (a_pc_en !== 1'b1) begin n_fail++; $display("FAIL lu_r0_pc_en: got %b expected 1", a_pc_en); end
        n_checks++; if (b_idex_bubble !== 1'b0) begin n_fail++; $display("FAIL lu_r0_bubble_b: got %b expected 0", b_idex_bubble); end
        idle_cycles(2);
    endtask

    task automatic test_rt_gating();
        @(negedge clk);
        set_ex_lw(5'd8);
        set_id(IT_I, OP_ADDI, 5'd3, 5'd8);
        #1;
        n_checks++; if (a_pc_en !== 1'b1) begin n_fail++; $display("FAIL addi_rt_pc_en: got %b expected 1", a_pc_en); end
        n_checks++; if (a_idex_bubble !== 1'b0) begin n_fail++; $display("FAIL addi_rt_bubble: got %b expected 0", a_idex_bubble); end
        set_id(IT_J, OP_J, 5'd8, 5'd0);
        #1;
        n_checks++; if (a_pc_en !== 1'b1) begin n_fail++; $display("FAIL j_rs_pc_en: got %b expected 1", a_pc_en); end
        set_id(IT_I, OP_SW, 5'd3, 5'd8);
        #1;
        n_checks++; if (a_pc_en !== 1'b0) begin n_fail++; $display("FAIL sw_rt_pc_en: got %b expected 0", a_pc_en); end
        n_checks++; if (a_idex_bubble !== 1'b1) begin n_fail++; $display("FAIL sw_rt_bubble: got %b expected 1", a_idex_bubble); end
        set_id(IT_I, OP_BNE, 5'd3, 5'd8);
        #1;
        n_checks++; if (a_pc_en !== 1'b0) begin n_fail++; $display("FAIL bne_rt_pc_en: got %b expected 0", a_pc_en); end
        idle_cycles(3);
    endtask

    task automatic test_redirect_priority();
        @(negedge clk);
        set_ex_lw(5'd5);
        set_id(IT_HALT, OP_HALT, 5'd5, 5'd5);
        ex_redirect = 1'b1;
        #1;
        n_checks++; if (a_ifid_flush !== 1'b1) begin n_fail++; $display("FAIL redir_flush: got %b expected 1", a_ifid_flush); end
        n_checks++; if (a_pc_en !== 1'b1) begin n_fail++; $display("FAIL redir_pc_en: got %b expected 1", a_pc_en); end
        n_checks++; if (a_idex_bubble !== 1'b1) begin n_fail++; $display("FAIL redir_bubble: got %b expected 1", a_idex_bubble); end
        n_checks++; if (b_pc_en !== 1'b1) begin n_fail++; $display("FAIL redir_b_pc_en: got %b expected 1", b_pc_en); end
        @(negedge clk);
        set_idle();
        #1;
        n_checks++; if (a_pc_en !== 1'b1) begin n_fail++; $display("FAIL redir_after_pc_en: got %b expected 1", a_pc_en); end
        n_checks++; if (a_ifid_flush !== 1'b0) begin n_fail++; $display("FAIL redir_after_flush: got %b expected 0", a_ifid_flush); end
        n_checks++; if (a_halted !== 1'b0) begin n_fail++; $display("FAIL redir_after_halted: got %b expected 0", a_halted); end
        n_checks++; if (b_pc_en !== 1'b1) begin n_fail++; $display("FAIL redir_after_b_pc_en: got %b expected 1", b_pc_en); end
        idle_cycles(1);
    endtask

    task automatic test_halt();
        logic exp_h;
        @(negedge clk);
        set_id(IT_HALT, OP_HALT, 5'd0, 5'd0);
        #1;
        n_checks++; if (a_pc_en !== 1'b0) begin n_fail++; $display("FAIL halt_det_pc_en: got %b expected 0", a_pc_en); end
        n_checks++; if (a_idex_bubble !== 1'b1) begin n_fail++; $display("FAIL halt_det_bubble: got %b expected 1", a_idex_bubble); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            exp_h = (k == 4);
            n_checks++; if (a_halted !== exp_h) begin n_fail++; $display("FAIL halt_edge%0d: got %b expected %b", k, a_halted, exp_h); end
            n_checks++; if (a_pc_en !== 1'b0) begin n_fail++; $display("FAIL halt_edge%0d_pc_en: got %b expected 0", k, a_pc_en); end
        end
        @(negedge clk);
        #1;
        n_checks++; if (a_halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got %b expected 1", a_halted); end
        resume = 1'b1;
        #1;
        n_checks++; if (a_ifid_flush !== 1'b1) begin n_fail++; $display("FAIL resume_flush: got %b expected 1", a_ifid_flush); end
        @(negedge clk);
        set_idle();
        #1;
        n_checks++; if (a_halted !== 1'b0) begin n_fail++; $display("FAIL resume_halted: got %b expected 0", a_halted); end
        n_checks++; if (a_pc_en !== 1'b1) begin n_fail++; $display("FAIL resume_pc_en: got %b expected 1", a_pc_en); end
        n_checks++; if (a_ifid_flush !== 1'b0) begin n_fail++; $display("FAIL resume_after_flush: got %b expected 0", a_ifid_flush); end
        // Reset in the middle of DRAIN returns straight to RUN
        @(negedge clk);
        set_id(IT_HALT, OP_HALT, 5'd0, 5'd0);
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        n_checks++; if (a_halted !== 1'b0) begin n_fail++; $display("FAIL drain_reset_halted: got %b expected 0", a_halted); end
        n_checks++; if (a_pc_en !== 1'b1) begin n_fail++; $display("FAIL drain_reset_pc_en: got %b expected 1", a_pc_en); end
    endtask

    task automatic test_stats();
        logic [15:0] exp_a;
        logic [3:0]  exp_b;
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_ex_lw(5'd5);
        set_id(IT_R, OP_RTYPE, 5'd5, 5'd6);
        ex_redirect = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (a_stall_count !== 16'd0) begin n_fail++; $display("FAIL stats_flush_a: got %0d expected 0", a_stall_count); end
        ex_redirect = 1'b0;
        repeat (5) @(negedge clk);
        #1;
`ifdef STALL_STATS_EN
        exp_a = 16'd5; exp_b = 4'd5;
`else
        exp_a = 16'd0; exp_b = 4'd0;
`endif
        n_checks++; if (a_stall_count !== exp_a) begin n_fail++; $display("FAIL stats_5_a: got %0d expected %0d", a_stall_count, exp_a); end
        n_checks++; if (b_stall_count !== exp_b) begin n_fail++; $display("FAIL stats_5_b: got %0d expected %0d", b_stall_count, exp_b); end
        repeat (15) @(negedge clk);
        #1;
`ifdef STALL_STATS_EN
        exp_a = 16'd20; exp_b = 4'd15;
`endif
        n_checks++; if (a_stall_count !== exp_a) begin n_fail++; $display("FAIL stats_20_a: got %0d expected %0d", a_stall_count, exp_a); end
        n_checks++; if (b_stall_count !== exp_b) begin n_fail++; $display("FAIL stats_sat_b: got %0d expected %0d", b_stall_count, exp_b); end
        // Flush cycles do not count even with the hazard present
        ex_redirect = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (a_stall_count !== exp_a) begin n_fail++; $display("FAIL stats_flush_hold_a: got %0d expected %0d", a_stall_count, exp_a); end
        idle_cycles(2);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_load_use();
        test_rt_gating();
        test_redirect_priority();
        test_halt();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
